// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared types and helpers for the SAR scan sequencer
package sar_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    ACCUM,
    OUTPUT,
    CALSTORE
  } state_t;

  // Calibration always averages 2^3 samples of the shorted front end
  localparam int CAL_AVG_LOG2 = 3;

  // Clamp a signed value into the unsigned code range 0 .. 2^res-1
  function automatic int sat_range(input int x, input int res);
    int hi;
    hi = (1 << res) - 1;
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// rtl/sar_bit_engine.sv - one RES-bit successive-approximation binary search
module sar_bit_engine #(
  parameter int RES        = 10,
  parameter int SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cmp,
  output logic [RES-1:0] dac_code,
  output logic [RES-1:0] code,
  output logic           last
);

  localparam int BW = $clog2(RES);
  localparam int SW = $clog2(SETTLE_CYC + 2);

  logic           active;
  logic [BW-1:0]  bit_idx;
  logic [SW-1:0]  settle;
  logic [RES-1:0] kept;
  logic           settled;

  // The comparator is trusted only on the final settle cycle of each trial bit
  assign settled  = (settle == SW'(SETTLE_CYC));
  assign dac_code = active ? (kept | (RES'(1) << bit_idx)) : '0;
  assign code     = kept;
  assign last     = active && settled && (bit_idx == '0);

  // Walk bits MSB to LSB, keeping each trial bit when the input is above the DAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      bit_idx <= '0;
      settle  <= '0;
      kept    <= '0;
    end else if (start) begin
      active  <= 1'b1;
      bit_idx <= BW'(RES - 1);
      settle  <= '0;
      kept    <= '0;
    end else if (active) begin
      if (settled) begin
        kept[bit_idx] <= cmp;
        settle        <= '0;
        if (bit_idx == '0) active <= 1'b0;
        else               bit_idx <= bit_idx - 1'b1;
      end else begin
        settle <= settle + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_adc_seq.sv
// rtl/sar_adc_seq.sv - multi-channel SAR scan sequencer with averaging and offset calibration
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter int RES        = 10,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cal,
  input  logic [NCH-1:0]               ch_mask,
  input  logic [1:0]                   avg_log2,
  input  logic                         cmp,
  output logic                         sample,
  output logic                         short_in,
  output logic [($clog2(NCH)|1)-1:0]   ch_sel,
  output logic [RES-1:0]               dac_code,
  output logic [RES-1:0]               result,
  output logic [($clog2(NCH)|1)-1:0]   result_ch,
  output logic                         valid,
  output logic                         busy,
  output logic                         cal_done,
  output logic [RES:0]                 offset
);

  localparam int CW  = $clog2(NCH) | 1;
  localparam int SCW = $clog2(SAMPLE_CYC + 1);

  state_t           state, state_d;
  logic [SCW-1:0]   samp_cnt;
  logic             cal_q, cal_pend, cal_mode, scan_act;
  logic [RES+2:0]   acc, acc_sum, avg;
  logic [3:0]       nsamp;
  logic [1:0]       avg_lat, n_eff;
  logic             boundary, start_cal, start_ch, last_samp, eng_start, eng_last;
  logic [RES-1:0]   eng_code;
  logic [CW-1:0]    low_ch, nxt_ch, pick_ch;
  logic             found_low, found_nxt;
  int               diff;

  sar_bit_engine #(.RES(RES), .SETTLE_CYC(SETTLE_CYC)) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .cmp      (cmp),
    .dac_code (dac_code),
    .code     (eng_code),
    .last     (eng_last)
  );

  assign busy      = (state != IDLE);
  assign sample    = (state == SAMPLE);
  assign short_in  = cal_mode && ((state == SAMPLE) || (state == CONVERT));
  assign eng_start = (state == SAMPLE) && (samp_cnt == SCW'(SAMPLE_CYC - 1));
  assign n_eff     = cal_mode ? 2'(CAL_AVG_LOG2) : avg_lat;
  assign acc_sum   = acc + {3'b000, eng_code};
  assign avg       = acc_sum >> n_eff;
  assign last_samp = ((nsamp + 4'd1) == (4'd1 << n_eff));
  assign diff      = int'(avg) - int'(signed'(offset));

  // Round-robin picker: next set mask bit above the current channel, else the lowest
  always_comb begin
    low_ch    = '0;
    nxt_ch    = '0;
    found_low = 1'b0;
    found_nxt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_mask[i] && !found_low) begin
        low_ch    = CW'(i);
        found_low = 1'b1;
      end
      if (ch_mask[i] && !found_nxt && (i > int'(ch_sel))) begin
        nxt_ch    = CW'(i);
        found_nxt = 1'b1;
      end
    end
    pick_ch = (scan_act && found_nxt) ? nxt_ch : low_ch;
  end

  // Next-state logic; a pending calibration wins over the next channel at every boundary
  always_comb begin
    state_d   = state;
    boundary  = (state == IDLE) || (state == OUTPUT) || (state == CALSTORE);
    start_cal = boundary && cal_pend;
    start_ch  = boundary && !cal_pend && en && (ch_mask != '0);
    case (state)
      IDLE, OUTPUT, CALSTORE: state_d = (start_cal || start_ch) ? SAMPLE : IDLE;
      SAMPLE:                 if (eng_start) state_d = CONVERT;
      CONVERT:                if (eng_last) state_d = ACCUM;
      ACCUM:                  state_d = last_samp ? (cal_mode ? CALSTORE : OUTPUT) : SAMPLE;
      default:                state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Calibration request edge detection; edges merge while a request is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_q    <= 1'b0;
      cal_pend <= 1'b0;
    end else begin
      cal_q    <= cal;
      cal_pend <= (cal_pend & ~start_cal) | (cal & ~cal_q);
    end
  end

  // Channel bookkeeping, accumulation, offset update and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt  <= '0;
      cal_mode  <= 1'b0;
      scan_act  <= 1'b0;
      acc       <= '0;
      nsamp     <= '0;
      avg_lat   <= '0;
      ch_sel    <= '0;
      result    <= '0;
      result_ch <= '0;
      valid     <= 1'b0;
      cal_done  <= 1'b0;
      offset    <= '0;
    end else begin
      valid    <= 1'b0;
      cal_done <= 1'b0;
      samp_cnt <= (state == SAMPLE) ? samp_cnt + 1'b1 : '0;
      if (start_cal) begin
        cal_mode <= 1'b1;
        acc      <= '0;
        nsamp    <= '0;
      end
      if (start_ch) begin
        cal_mode <= 1'b0;
        acc      <= '0;
        nsamp    <= '0;
        ch_sel   <= pick_ch;
        avg_lat  <= avg_log2;
        scan_act <= 1'b1;
      end else if (boundary && !start_cal) begin
        scan_act <= 1'b0;
      end
      if (state == ACCUM) begin
        acc   <= acc_sum;
        nsamp <= nsamp + 4'd1;
        if (last_samp) begin
          if (cal_mode) begin
            offset   <= (RES+1)'(int'(avg) - (1 << (RES - 1)));
            cal_done <= 1'b1;
          end else begin
            result    <= RES'(sat_range(diff, RES));
            result_ch <= ch_sel;
            valid     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb/tb_sar_adc_seq.sv - scoreboard bench for the SAR scan sequencer
module tb_sar_adc_seq;

  localparam int RES = 10;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           cal = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [1:0]     avg_log2 = '0;
  logic           cmp;
  logic           sample, short_in, valid, busy, cal_done;
  logic [2:0]     ch_sel, result_ch;
  logic [RES-1:0] dac_code, result;
  logic [RES:0]   offset;

  typedef struct {
    bit is_cal;
    int ch;
    int val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vin[4] = '{0, 0, 0, 0};
  int   off_model = 0;
  bit   alt_en = 1'b0;
  int   alt_base = 0;
  int   samp_no = 0;
  int   valid_cnt = 0;
  int   bad_sel_cnt = 0;
  bit   scan_chk = 1'b0;

  sar_adc_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cal       (cal),
    .ch_mask   (ch_mask),
    .avg_log2  (avg_log2),
    .cmp       (cmp),
    .sample    (sample),
    .short_in  (short_in),
    .ch_sel    (ch_sel),
    .dac_code  (dac_code),
    .result    (result),
    .result_ch (result_ch),
    .valid     (valid),
    .busy      (busy),
    .cal_done  (cal_done),
    .offset    (offset)
  );

  always #5 clk = ~clk;

  // Analog level sits at the centre of its code, so "vin above DAC" is level >= dac_code
  always_comb begin
    int lvl;
    if (short_in)    lvl = (1 << (RES - 1)) + off_model;
    else if (alt_en) lvl = ((((samp_no - alt_base) & 1) != 0) ? 500 : 503) + off_model;
    else             lvl = vin[int'(ch_sel) & 3] + off_model;
    cmp = (lvl >= int'(dac_code));
  end

  always @(posedge sample) samp_no <= samp_no + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit is_cal, input int ch, input int val);
    exp_t e;
    e.is_cal = is_cal;
    e.ch     = ch;
    e.val    = val;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or a calibration
  always @(negedge clk) begin
    if (!rst) begin
      if (valid || cal_done) chk("pulse_exclusive", int'(valid & cal_done), 0);
      if (scan_chk && busy && (ch_sel == 3'd0 || ch_sel == 3'd2)) bad_sel_cnt <= bad_sel_cnt + 1;
      if (valid) begin
        valid_cnt <= valid_cnt + 1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %0d ch %0d, none expected", result, result_ch);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("kind_valid", 0, int'(e.is_cal));
          chk("result", int'(result), e.val);
          chk("result_ch", int'(result_ch), e.ch);
        end
      end
      if (cal_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cal_done: got offset %0d, none expected", $signed(offset));
        end else begin
          exp_t e;
          int o;
          e = q.pop_front();
          o = $signed(offset);
          chk("kind_cal", 1, int'(e.is_cal));
          chk("offset", o, e.val);
        end
      end
    end
  end

  task automatic wait_valids(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (valid) got++;
    end
    chk("valids_seen", got, n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("back_to_idle", int'(busy), 0);
  endtask

  task automatic run_channels(input int n);
    @(negedge clk);
    en = 1'b1;
    wait_valids(n, 400 * n);
    en = 1'b0;
    wait_idle(400);
  endtask

  task automatic run_cal(input int expect_off);
    int cyc = 0;
    push(1'b1, 0, expect_off);
    @(negedge clk);
    cal = 1'b1;
    @(negedge clk);
    cal = 1'b0;
    while (!cal_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk("cal_done_seen", int'(cal_done), 1);
    wait_idle(50);
  endtask

  initial begin
    int cyc;
    int base;
    int saw_busy;

    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_offset", int'(offset), 0);
    chk("rst_dac", int'(dac_code), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single sample with latency measured from en
    vin = '{613, 0, 0, 0};
    ch_mask = 4'b0001;
    avg_log2 = 2'd0;
    push(1'b0, 0, 613);
    en = 1'b1;
    cyc = 0;
    while (!valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    en = 1'b0;
    chk("latency", cyc, 26);
    wait_idle(50);

    // Empty mask keeps the sequencer idle
    ch_mask = 4'b0000;
    en = 1'b1;
    saw_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    en = 1'b0;
    chk("mask0_idle", saw_busy, 0);

    // Round-robin scan over channels 1 and 3
    vin = '{100, 200, 300, 400};
    ch_mask = 4'b1010;
    base = bad_sel_cnt;
    scan_chk = 1'b1;
    push(1'b0, 1, 200);
    push(1'b0, 3, 400);
    push(1'b0, 1, 200);
    push(1'b0, 3, 400);
    run_channels(4);
    scan_chk = 1'b0;
    @(negedge clk);
    chk("scan_skip", bad_sel_cnt - base, 0);

    // Eight-sample average of alternating 500/503 truncates to 501
    ch_mask = 4'b0001;
    avg_log2 = 2'd3;
    alt_base = samp_no;
    alt_en = 1'b1;
    push(1'b0, 0, 501);
    run_channels(1);
    alt_en = 1'b0;
    avg_log2 = 2'd0;

    // Calibration from idle with +7 offset, then corrected conversions
    off_model = 7;
    run_cal(7);
    vin = '{10, 0, 0, 0};
    push(1'b0, 0, 10);
    run_channels(1);
    vin = '{3, 0, 0, 0};
    push(1'b0, 0, 3);
    run_channels(1);

    // Offset drifts away: correction goes negative and clamps at zero
    off_model = 0;
    push(1'b0, 0, 0);
    run_channels(1);

    // Negative offset, then full-scale input clamps at the top code
    off_model = -20;
    run_cal(-20);
    off_model = 0;
    vin = '{1023, 0, 0, 0};
    push(1'b0, 0, 1023);
    run_channels(1);

    // Two cal edges inside one channel give one calibration between two results
    off_model = 4;
    vin = '{50, 0, 0, 0};
    push(1'b0, 0, 74);
    push(1'b1, 0, 4);
    push(1'b0, 0, 50);
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    cal = 1'b1;
    @(negedge clk);
    cal = 1'b0;
    repeat (4) @(negedge clk);
    cal = 1'b1;
    @(negedge clk);
    cal = 1'b0;
    wait_valids(2, 800);
    en = 1'b0;
    wait_idle(400);

    // en dropped mid-conversion still finishes exactly one channel
    base = valid_cnt;
    push(1'b0, 0, 50);
    @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_idle(100);
    @(negedge clk);
    chk("en_drop_one_valid", valid_cnt - base, 1);

    // Reset in the middle of a conversion clears everything at once
    en = 1'b1;
    cyc = 0;
    while (dac_code == '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_convert", int'(dac_code != '0), 1);
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dac", int'(dac_code), 0);
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_offset", int'(offset), 0);
    chk("midrst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
